// File: rtl/decode_frontend.sv
// Decode-side front end: IF/ID pipeline register, control-transfer resolution,
// wrong-path squash and the architectural IAR/FPSR registers.
module decode_frontend #(
    parameter logic [0:5] NopFunction = 6'h15,
    parameter logic [0:5] Link        = 6'h1f
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [0:5]  OpCode,
    input  logic [0:5]  Function,
    input  logic [0:31] PCPlusFour,
    input  logic [0:4]  Rs1,
    input  logic [0:4]  Rs2,
    input  logic [0:4]  Rd,
    input  logic [0:15] Immediate,
    input  logic [0:31] RegData1,
    input  logic        FpsrWe,
    input  logic [0:31] FpsrWData,
    output logic [0:4]  ReadAddr1,
    output logic [0:4]  ReadAddr2,
    output logic [0:15] IdImmediate,
    output logic [0:5]  IdFunction,
    output logic [0:1]  JumpType,
    output logic        BranchCond,
    output logic        CondSrc,
    output logic        BranchResult,
    output logic [0:31] JumpReg,
    output logic [0:31] IAR,
    output logic [0:31] FPSR,
    output logic [0:5]  DecodeRd,
    output logic [0:31] DecodePCPlusFour,
    output logic [0:5]  DecodeOpCode
);

    typedef struct packed {
        logic [0:5]  op;
        logic [0:5]  fn;
        logic [0:31] pc4;
        logic [0:4]  rs1;
        logic [0:4]  rs2;
        logic [0:4]  rd;
        logic [0:15] imm;
    } ifid_t;

    localparam ifid_t Nop = '{op: 6'h00, fn: NopFunction, pc4: '0,
                              rs1: '0, rs2: '0, rd: '0, imm: '0};

    localparam logic [0:5] OpJ    = 6'h02;
    localparam logic [0:5] OpJal  = 6'h03;
    localparam logic [0:5] OpBeqz = 6'h04;
    localparam logic [0:5] OpBnez = 6'h05;
    localparam logic [0:5] OpBfpt = 6'h06;
    localparam logic [0:5] OpBfpf = 6'h07;
    localparam logic [0:5] OpRfe  = 6'h10;
    localparam logic [0:5] OpTrap = 6'h11;
    localparam logic [0:5] OpJr   = 6'h12;
    localparam logic [0:5] OpJalr = 6'h13;

    ifid_t       ifid;
    ifid_t       fetch;
    logic        squash;
    logic [0:31] iar;
    logic [0:31] fpsr;

    logic        is_trap;
    logic        is_rfe;
    logic        is_link;
    logic        no_rd;
    logic        fp_dest;
    logic        cond_val;
    logic        taken;

    assign fetch = '{op: OpCode, fn: Function, pc4: PCPlusFour, rs1: Rs1,
                     rs2: Rs2, rd: Rd, imm: Immediate};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid   <= Nop;
            squash <= 1'b0;
            iar    <= '0;
            fpsr   <= '0;
        end else begin
            if (FpsrWe)
                fpsr <= FpsrWData;
            if (!stall) begin
                ifid   <= squash ? Nop : fetch;
                // A taken transfer on this edge bubbles the following load
                squash <= taken;
                if (is_trap)
                    iar <= ifid.pc4;
            end
        end
    end

    always_comb begin
        JumpType   = 2'b00;
        BranchCond = 1'b0;
        CondSrc    = 1'b0;
        is_trap    = 1'b0;
        is_rfe     = 1'b0;
        is_link    = 1'b0;
        no_rd      = 1'b0;
        unique case (ifid.op)
            OpJ:    begin JumpType = 2'b10; no_rd = 1'b1; end
            OpJal:  begin JumpType = 2'b10; is_link = 1'b1; end
            OpBeqz: begin JumpType = 2'b01; no_rd = 1'b1; end
            OpBnez: begin JumpType = 2'b01; BranchCond = 1'b1; no_rd = 1'b1; end
            OpBfpt: begin JumpType = 2'b01; BranchCond = 1'b1; CondSrc = 1'b1; no_rd = 1'b1; end
            OpBfpf: begin JumpType = 2'b01; CondSrc = 1'b1; no_rd = 1'b1; end
            OpJr:   begin JumpType = 2'b11; no_rd = 1'b1; end
            OpJalr: begin JumpType = 2'b11; is_link = 1'b1; end
            OpRfe:  begin JumpType = 2'b11; is_rfe = 1'b1; no_rd = 1'b1; end
            OpTrap: begin is_trap = 1'b1; no_rd = 1'b1; end
            default: no_rd = (ifid.op inside {[6'h28:6'h2f]});
        endcase
    end

    assign fp_dest = (ifid.op == 6'h01) || (ifid.op == 6'h26) || (ifid.op == 6'h27);

    assign BranchResult = (RegData1 == '0);
    // Condition value is "nonzero/true"; BranchCond says which value takes it
    assign cond_val = CondSrc ? fpsr[31] : !BranchResult;
    assign taken    = JumpType[0] || (JumpType == 2'b01 && cond_val == BranchCond) || is_trap;

    assign JumpReg          = is_rfe ? iar : RegData1;
    assign DecodeRd         = is_link ? Link : (no_rd ? 6'h00 : {fp_dest, ifid.rd});
    assign ReadAddr1        = ifid.rs1;
    assign ReadAddr2        = ifid.rs2;
    assign IdImmediate      = ifid.imm;
    assign IdFunction       = ifid.fn;
    assign DecodePCPlusFour = ifid.pc4;
    assign DecodeOpCode     = ifid.op;
    assign IAR              = iar;
    assign FPSR             = fpsr;

endmodule

// File: tb/tb_decode_frontend.sv
// Directed bench for decode_frontend: decode, squash bubble, stall hold,
// TRAP/RFE through IAR, FPSR-conditioned branch and asynchronous reset.
module tb_decode_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [0:5]  OpCode, Function;
    logic [0:31] PCPlusFour;
    logic [0:4]  Rs1, Rs2, Rd;
    logic [0:15] Immediate;
    logic [0:31] RegData1;
    logic        FpsrWe;
    logic [0:31] FpsrWData;
    logic [0:4]  ReadAddr1, ReadAddr2;
    logic [0:15] IdImmediate;
    logic [0:5]  IdFunction;
    logic [0:1]  JumpType;
    logic        BranchCond, CondSrc, BranchResult;
    logic [0:31] JumpReg, IAR, FPSR;
    logic [0:5]  DecodeRd;
    logic [0:31] DecodePCPlusFour;
    logic [0:5]  DecodeOpCode;

    int n_chk  = 0;
    int n_pass = 0;

    decode_frontend dut (
        .clk(clk), .reset(reset), .stall(stall),
        .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Immediate(Immediate),
        .RegData1(RegData1), .FpsrWe(FpsrWe), .FpsrWData(FpsrWData),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .IdImmediate(IdImmediate), .IdFunction(IdFunction),
        .JumpType(JumpType), .BranchCond(BranchCond), .CondSrc(CondSrc),
        .BranchResult(BranchResult), .JumpReg(JumpReg), .IAR(IAR), .FPSR(FPSR),
        .DecodeRd(DecodeRd), .DecodePCPlusFour(DecodePCPlusFour),
        .DecodeOpCode(DecodeOpCode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc4);
        OpCode     = op;
        Function   = 6'h20;
        Rd         = rd;
        Rs1        = 5'd1;
        Rs2        = 5'd2;
        Immediate  = 16'h1234;
        PCPlusFour = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; RegData1 = 32'h0;
        FpsrWe = 1'b0; FpsrWData = 32'h0;
        fetch(6'h00, 5'd0, 32'h0);
        #3;
        chk("rst_op", 32'(DecodeOpCode), 32'h00);
        chk("rst_fn", 32'(IdFunction), 32'h15);
        chk("rst_jt", 32'(JumpType), 32'h0);
        chk("rst_rd", 32'(DecodeRd), 32'h0);
        chk("rst_iar", IAR, 32'h0);
        chk("rst_fpsr", FPSR, 32'h0);
        tick(); reset = 1'b0;

        // straight-line ALU ops, FP destination, store
        fetch(6'h00, 5'd3, 32'h10); tick();
        chk("add_rd", 32'(DecodeRd), 32'h03);
        chk("add_jt", 32'(JumpType), 32'h0);
        chk("add_ra1", 32'(ReadAddr1), 32'h1);
        chk("add_ra2", 32'(ReadAddr2), 32'h2);
        chk("add_imm", 32'(IdImmediate), 32'h1234);
        chk("add_pc4", DecodePCPlusFour, 32'h10);
        fetch(6'h01, 5'd5, 32'h14); tick();
        chk("fp_rd", 32'(DecodeRd), 32'h25);
        chk("fp_nosquash_fn", 32'(IdFunction), 32'h20);
        fetch(6'h2b, 5'd6, 32'h18); tick();
        chk("store_rd", 32'(DecodeRd), 32'h00);

        // BEQZ taken: one bubble on the load after the taken edge
        RegData1 = 32'h0;
        fetch(6'h04, 5'd7, 32'h1c); tick();
        chk("beqz_br", 32'(BranchResult), 32'h1);
        chk("beqz_bc", 32'(BranchCond), 32'h0);
        chk("beqz_jt", 32'(JumpType), 32'h1);
        chk("beqz_cs", 32'(CondSrc), 32'h0);
        chk("beqz_rd", 32'(DecodeRd), 32'h0);
        fetch(6'h00, 5'd8, 32'h20); tick();
        fetch(6'h00, 5'd9, 32'h24); tick();
        chk("beqz_nop_op", 32'(DecodeOpCode), 32'h00);
        chk("beqz_nop_fn", 32'(IdFunction), 32'h15);
        chk("beqz_nop_rd", 32'(DecodeRd), 32'h00);
        fetch(6'h00, 5'd10, 32'h28); tick();
        chk("beqz_after", 32'(DecodeRd), 32'h0a);

        // BNEZ with zero register: not taken, no bubble
        fetch(6'h05, 5'd0, 32'h2c); tick();
        chk("bnez_bc", 32'(BranchCond), 32'h1);
        fetch(6'h00, 5'd11, 32'h30); tick();
        fetch(6'h00, 5'd12, 32'h34); tick();
        chk("bnez_nt_rd", 32'(DecodeRd), 32'h0c);
        chk("bnez_nt_fn", 32'(IdFunction), 32'h20);

        // JALR held by stall
        RegData1 = 32'hdeadbeef;
        fetch(6'h13, 5'd1, 32'h200); tick();
        stall = 1'b1;
        fetch(6'h00, 5'd12, 32'h204);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("jalr_hold_op", 32'(DecodeOpCode), 32'h13);
            chk("jalr_hold_rd", 32'(DecodeRd), 32'h1f);
            chk("jalr_hold_jt", 32'(JumpType), 32'h3);
            chk("jalr_hold_jr", JumpReg, 32'hdeadbeef);
        end
        stall = 1'b0; tick();
        chk("jalr_rel_rd", 32'(DecodeRd), 32'h0c);
        fetch(6'h00, 5'd13, 32'h208); tick();
        chk("jalr_nop_fn", 32'(IdFunction), 32'h15);
        fetch(6'h00, 5'd14, 32'h20c); tick();
        chk("jalr_after", 32'(DecodeRd), 32'h0e);

        // TRAP then RFE
        RegData1 = 32'h55;
        fetch(6'h11, 5'd3, 32'h104); tick();
        chk("trap_jt", 32'(JumpType), 32'h0);
        chk("trap_rd", 32'(DecodeRd), 32'h0);
        chk("trap_iar_pre", IAR, 32'h0);
        fetch(6'h00, 5'd1, 32'h300); tick();
        chk("trap_iar", IAR, 32'h104);
        fetch(6'h00, 5'd2, 32'h304); tick();
        chk("trap_nop_fn", 32'(IdFunction), 32'h15);
        fetch(6'h10, 5'd0, 32'h308); tick();
        chk("rfe_jt", 32'(JumpType), 32'h3);
        chk("rfe_jr", JumpReg, 32'h104);
        fetch(6'h00, 5'd1, 32'h30c); tick();
        fetch(6'h00, 5'd2, 32'h310); tick();
        chk("rfe_nop_fn", 32'(IdFunction), 32'h15);

        // BFPT with FPSR written on the same edge that loads it
        RegData1 = 32'h1;
        fetch(6'h06, 5'd0, 32'h400);
        FpsrWe = 1'b1; FpsrWData = 32'h1;
        tick();
        FpsrWe = 1'b0; FpsrWData = 32'h0;
        chk("bfpt_fpsr", FPSR, 32'h1);
        chk("bfpt_cs", 32'(CondSrc), 32'h1);
        chk("bfpt_bc", 32'(BranchCond), 32'h1);
        chk("bfpt_jt", 32'(JumpType), 32'h1);
        fetch(6'h00, 5'd15, 32'h404); tick();
        fetch(6'h00, 5'd16, 32'h408); tick();
        chk("bfpt_nop_fn", 32'(IdFunction), 32'h15);

        // reset mid-stream with a pending squash
        fetch(6'h03, 5'd4, 32'h500); tick();
        chk("jal_rd", 32'(DecodeRd), 32'h1f);
        chk("jal_jt", 32'(JumpType), 32'h2);
        fetch(6'h00, 5'd17, 32'h504); tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_op", 32'(DecodeOpCode), 32'h00);
        chk("mid_rst_jt", 32'(JumpType), 32'h0);
        chk("mid_rst_rd", 32'(DecodeRd), 32'h0);
        chk("mid_rst_iar", IAR, 32'h0);
        chk("mid_rst_fpsr", FPSR, 32'h0);
        tick(); reset = 1'b0;
        fetch(6'h00, 5'd18, 32'h600); tick();
        chk("post_rst_rd", 32'(DecodeRd), 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_frontend.md
Name: decode_frontend

Overview:
- Decode-side counterpart of the fetch stage: the IF/ID pipeline register plus the control logic that produces the fetch-steering signals (JumpType, BranchCond, CondSrc, BranchResult, JumpReg, IAR, FPSR, DecodeRd, DecodePCPlusFour, DecodeOpCode).
- Captures fetched instruction fields, supplies register-file read addresses, and resolves control transfers in ID.
- Squashes the wrong-path instruction after a taken transfer.
- Owns the architectural IAR and FPSR registers.

Parameters:
NopFunction, 6'h15, Function code of the inserted NOP (OpCode 6'h00)
Link, 6'h1f, DecodeRd value for JAL/JALR (GPR r31, FP bit 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold the IF/ID register and squash state
OpCode  in  [0:5]  from fetch
Function  in  [0:5]  from fetch
PCPlusFour  in  [0:31]  from fetch
Rs1, Rs2, Rd  in  [0:4] each  from fetch
Immediate  in  [0:15]  from fetch
RegData1  in  [0:31]  register-file read data for ID Rs1
FpsrWe  in  1  write-back strobe for FPSR
FpsrWData  in  [0:31]  write-back data for FPSR
ReadAddr1, ReadAddr2  out  [0:4] each  ID Rs1/Rs2 to register file
IdImmediate  out  [0:15]  ID immediate
IdFunction  out  [0:5]  ID function
JumpType  out  [0:1]  00 none, 01 branch, 10 jump-imm, 11 jump-reg
BranchCond  out  1  0 = taken when condition is zero, 1 = taken when nonzero
CondSrc  out  1  0 = GPR test, 1 = FPSR
BranchResult  out  1  RegData1 == 0
JumpReg  out  [0:31]  RegData1
IAR  out  [0:31]  interrupt address register
FPSR  out  [0:31]  FP status register
DecodeRd  out  [0:5]  {fp, reg} destination of ID instruction
DecodePCPlusFour  out  [0:31]  ID PC+4
DecodeOpCode  out  [0:5]  ID opcode

Behaviour:
- Reset:
  - Asynchronous, active-high, one clock domain.
  - IF/ID register holds a NOP (OpCode 6'h00, Function NopFunction); all other IF/ID fields are 0.
  - IAR, FPSR and the squash flag are 0.
  - All outputs derive from these values, so JumpType is 00 and DecodeRd is 0.
  - Reset mid-operation discards the in-flight instruction and any pending squash.
- IF/ID register load, on each rising edge when stall = 0:
  - If squash = 1: load the NOP and clear squash.
  - Otherwise: load the fetch inputs.
  - stall = 1 holds all state, including squash.
- ID decode on the registered opcode:
  - J 02 → JumpType 10.
  - JAL 03 → JumpType 10, DecodeRd = Link.
  - BEQZ 04 → JumpType 01, BranchCond 0, CondSrc 0.
  - BNEZ 05 → JumpType 01, BranchCond 1, CondSrc 0.
  - BFPT 06 → JumpType 01, BranchCond 1, CondSrc 1.
  - BFPF 07 → JumpType 01, BranchCond 0, CondSrc 1.
  - JR 12 → JumpType 11.
  - JALR 13 → JumpType 11, DecodeRd = Link.
  - All other opcodes → JumpType 00; BranchCond and CondSrc are 0.
- DecodeRd for all other opcodes:
  - Branches, jumps, stores (28–2F) and TRAP/RFE → 0.
  - Otherwise {fp, Rd}, with fp = 1 for OpCode 01, 26 or 27.
- Taken condition:
  - JumpType 1x, or
  - JumpType 01 with the selected condition met: the GPR test uses BranchResult; the FPSR test uses FPSR[31].
  - The condition is compared against BranchCond.
- Squash: squash is set on an edge where stall = 0 and the ID instruction is taken; the next load is then a NOP (1 bubble).
- TRAP (11) in ID with stall = 0: IAR ← DecodePCPlusFour on that edge, and the transfer counts as taken (squash set).
- RFE (10) in ID: treated as JumpType 11 with JumpReg = IAR.
- FPSR write: FPSR ← FpsrWData when FpsrWe = 1. This is independent of stall and has priority over nothing.
- Combinational outputs: ReadAddr, JumpReg, BranchResult and the control outputs are combinational from the IF/ID register and RegData1, with zero added latency.
- Taken instruction held by stall: the taken instruction stays in ID with outputs stable; squash is set only on its release edge.

Test Plan:
- Reset: assert reset mid-stream → DecodeOpCode 00, JumpType 00, DecodeRd 0, IAR 0, FPSR 0 immediately, without waiting for a clock edge.
- Straight-line ADD r3: fetch OpCode 00 Rd 3 → next cycle DecodeRd 6'h03, JumpType 00; no squash.
- BEQZ taken: RegData1 0 → BranchResult 1, BranchCond 0, JumpType 01; following fetched instruction replaced by NOP (Function 6'h15); the instruction after that passes.
- JALR with stall: hold 3 cycles → outputs stable, DecodeRd 6'h1f, JumpReg = RegData1; the NOP is inserted on the cycle after release.
- TRAP at PC+4 = 0x00000104 → IAR = 0x00000104; a following RFE gives JumpType 11 with JumpReg 0x00000104.
- BFPT: FpsrWe with 0x00000001 the same cycle BFPT is loaded → next cycle FPSR[31] = 1, CondSrc 1, taken, squash.
